// File: rtl/count_seq_checker_pkg.sv
// ----------------------------------------------------------------------------
// count_chk_pkg
// Shared types and default constants for the count sequence checker.
//   state_t       : sequence tracker state (IDLE, SYNC, LOCK), 2 bits
//   DEF_WIDTH     : default width of the monitored count
//   DEF_SYNC_LEN  : default number of consecutive good increments to lock
//   DEF_ERR_CNT_W : default width of the saturating error counter
//   MATCH_W       : width of the match counter (SYNC_LEN is at most 15)
// ----------------------------------------------------------------------------
package count_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_SYNC_LEN  = 2;
    localparam int DEF_ERR_CNT_W = 8;
    localparam int MATCH_W       = 4;

endpackage

// File: rtl/count_seq_checker_sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up counter that sticks at all-ones. A clear on the same edge as an
// increment yields 1, so the event that coincides with the clear is kept.
// Ports:
//   i_clk   : rising-edge clock
//   i_rst_n : asynchronous active-low reset
//   i_inc   : increment request
//   i_clr   : synchronous clear
//   o_cnt   : current count (registered)
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? W'(1) : '0;
        end else if (i_inc && !(&r_cnt)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/count_seq_checker.sv
// ----------------------------------------------------------------------------
// count_seq_checker
// Monitors a counter output and locks onto a modulo-2^WIDTH incrementing
// sequence. Deviations while locked are flagged, counted and drop the lock.
// Optional build macro COUNT_SEQ_CHECKER_CAPTURE_EN adds capture of the
// expected/actual values of the first error since reset or clear.
// Ports:
//   clk        : rising-edge clock
//   reset      : asynchronous active-low reset
//   en         : sample qualifier
//   count      : monitored counter value
//   clr_err    : synchronous clear of err_sticky / err_cnt (and capture)
//   locked     : checker is in LOCK
//   err_pulse  : one-cycle flag for a mismatch detected in LOCK
//   err_sticky : set on any error, held until clr_err or reset
//   err_cnt    : saturating error count
//   err_exp    : (capture build) expected value at first error
//   err_act    : (capture build) observed value at first error
// ----------------------------------------------------------------------------
module count_seq_checker
    import count_chk_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int SYNC_LEN  = DEF_SYNC_LEN,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [WIDTH-1:0]     count,
    input  logic                 clr_err,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_cnt
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    ,
    output logic [WIDTH-1:0]     err_exp,
    output logic [WIDTH-1:0]     err_act
`endif
);

    localparam logic [MATCH_W-1:0] SYNC_LEN_M = MATCH_W'(SYNC_LEN);

    state_t             r_state;
    logic [WIDTH-1:0]   r_prev;
    logic [MATCH_W-1:0] r_match;
    logic               r_locked;
    logic               r_err_pulse;
    logic               r_err_sticky;

    logic [WIDTH-1:0]   w_exp;
    logic               w_hit;
    logic               w_err;
    logic [MATCH_W-1:0] w_match_inc;

    // Natural wrap of the WIDTH-bit add makes 2^WIDTH-1 -> 0 a good step.
    assign w_exp       = r_prev + WIDTH'(1);
    assign w_hit       = (count == w_exp);
    assign w_err       = en && (r_state == LOCK) && !w_hit;
    assign w_match_inc = r_match + MATCH_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_prev       <= '0;
            r_match      <= '0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_err_pulse <= w_err;
            // An error on the clearing edge wins over the clear.
            if (w_err) begin
                r_err_sticky <= 1'b1;
            end else if (clr_err) begin
                r_err_sticky <= 1'b0;
            end
            if (en) begin
                r_prev <= count;
                case (r_state)
                    IDLE: begin
                        r_match <= '0;
                        r_state <= SYNC;
                    end
                    SYNC: begin
                        if (w_hit) begin
                            r_match <= w_match_inc;
                            if (w_match_inc == SYNC_LEN_M) begin
                                r_state  <= LOCK;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_match <= '0;
                        end
                    end
                    LOCK: begin
                        if (!w_hit) begin
                            r_match  <= '0;
                            r_state  <= SYNC;
                            r_locked <= 1'b0;
                        end
                    end
                    default: begin
                        r_state  <= IDLE;
                        r_locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .i_clk  (clk),
        .i_rst_n(reset),
        .i_inc  (w_err),
        .i_clr  (clr_err),
        .o_cnt  (err_cnt)
    );

    assign locked     = r_locked;
    assign err_pulse  = r_err_pulse;
    assign err_sticky = r_err_sticky;

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    logic [WIDTH-1:0] r_err_exp;
    logic [WIDTH-1:0] r_err_act;

    // Capture only the first error since reset/clear; a clear on the same
    // edge as an error re-arms the capture so that error is taken.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_exp <= '0;
            r_err_act <= '0;
        end else if (w_err && (!r_err_sticky || clr_err)) begin
            r_err_exp <= w_exp;
            r_err_act <= count;
        end else if (clr_err) begin
            r_err_exp <= '0;
            r_err_act <= '0;
        end
    end

    assign err_exp = r_err_exp;
    assign err_act = r_err_act;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;

    logic       clk;
    logic       reset;
    logic       en;
    logic [3:0] count;
    logic       clr_err;

    logic       locked,  err_pulse,  err_sticky;
    logic [7:0] err_cnt;
    logic       s_locked, s_err_pulse, s_err_sticky;
    logic [1:0] s_err_cnt;
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    logic [3:0] err_exp, err_act, s_err_exp, s_err_act;
`endif

    int tests;
    int fails;

    count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .count(count), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_cnt(err_cnt)
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        , .err_exp(err_exp), .err_act(err_act)
`endif
    );

    count_seq_checker #(.WIDTH(4), .SYNC_LEN(2), .ERR_CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .en(en), .count(count), .clr_err(clr_err),
        .locked(s_locked), .err_pulse(s_err_pulse), .err_sticky(s_err_sticky),
        .err_cnt(s_err_cnt)
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        , .err_exp(s_err_exp), .err_act(s_err_act)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs at the falling edge, return 1 ns after the
    // following rising edge so outputs can be sampled.
    task automatic drive(input logic e, input logic [3:0] c, input logic cl);
        @(negedge clk);
        en      = e;
        count   = c;
        clr_err = cl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; en = 1'b0; count = 4'd0; clr_err = 1'b0;
        #12;
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL reset_err_pulse: got %0b expected 0", err_pulse); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL reset_err_sticky: got %0b expected 0", err_sticky); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt); end
        reset = 1'b1;
    endtask

    task automatic test_lock_wrap;
        int pulses;
        logic [3:0] v;
        pulses = 0;
        for (int i = 0; i < 18; i++) begin
            v = 4'(i);
            drive(1'b1, v, 1'b0);
            if (err_pulse) pulses++;
            if (i == 1) begin
                tests++; if (locked !== 1'b0) begin fails++; $display("FAIL wrap_locked_early: got %0b expected 0", locked); end
            end
            if (i == 2) begin
                tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked_3rd: got %0b expected 1", locked); end
            end
        end
        tests++; if (pulses != 0) begin fails++; $display("FAIL wrap_err_pulses: got %0d expected 0", pulses); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL wrap_locked_end: got %0b expected 1", locked); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL wrap_err_cnt: got %0d expected 0", err_cnt); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL wrap_err_sticky: got %0b expected 0", err_sticky); end
    endtask

    task automatic test_glitch;
        // prev is 1 and locked
        drive(1'b1, 4'd2, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd4, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd6, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL glitch_pre_pulse: got %0b expected 0", err_pulse); end
        drive(1'b1, 4'd9, 1'b0);
        tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL glitch_pulse: got %0b expected 1", err_pulse); end
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL glitch_err_cnt: got %0d expected 1", err_cnt); end
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL glitch_sticky: got %0b expected 1", err_sticky); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL glitch_unlock: got %0b expected 0", locked); end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        tests++; if (err_exp !== 4'd7) begin fails++; $display("FAIL glitch_err_exp: got %0d expected 7", err_exp); end
        tests++; if (err_act !== 4'd9) begin fails++; $display("FAIL glitch_err_act: got %0d expected 9", err_act); end
`endif
        drive(1'b1, 4'd10, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL glitch_pulse_width: got %0b expected 0", err_pulse); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL glitch_relock_early: got %0b expected 0", locked); end
        drive(1'b1, 4'd11, 1'b0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL glitch_relock: got %0b expected 1", locked); end
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL glitch_err_cnt_hold: got %0d expected 1", err_cnt); end
    endtask

    task automatic test_hold_gating;
        logic [3:0] junk [5];
        junk = '{4'd7, 4'd0, 4'd3, 4'd9, 4'd1};
        drive(1'b1, 4'd12, 1'b0);
        drive(1'b1, 4'd13, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL hold_pre_pulse: got %0b expected 0", err_pulse); end
        drive(1'b1, 4'd13, 1'b0);
        tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL hold_pulse: got %0b expected 1", err_pulse); end
        tests++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL hold_err_cnt: got %0d expected 2", err_cnt); end
        drive(1'b1, 4'd14, 1'b0);
        drive(1'b1, 4'd15, 1'b0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL hold_relock: got %0b expected 1", locked); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, junk[i], 1'b0);
            tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL gate_pulse_%0d: got %0b expected 0", i, err_pulse); end
            tests++; if (locked !== 1'b1) begin fails++; $display("FAIL gate_locked_%0d: got %0b expected 1", i, locked); end
        end
        tests++; if (err_cnt !== 8'd2) begin fails++; $display("FAIL gate_err_cnt: got %0d expected 2", err_cnt); end
        drive(1'b1, 4'd0, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL gate_resume_pulse: got %0b expected 0", err_pulse); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL gate_resume_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_clear_collision;
        // prev is 0 and locked; 5 is a mismatch (expected 1)
        drive(1'b1, 4'd5, 1'b0);
        tests++; if (err_cnt !== 8'd3) begin fails++; $display("FAIL coll_err_cnt_pre: got %0d expected 3", err_cnt); end
        drive(1'b1, 4'd6, 1'b0);
        drive(1'b1, 4'd7, 1'b0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL coll_relock: got %0b expected 1", locked); end
        drive(1'b1, 4'd3, 1'b1);
        tests++; if (err_cnt !== 8'd1) begin fails++; $display("FAIL coll_err_cnt: got %0d expected 1", err_cnt); end
        tests++; if (err_sticky !== 1'b1) begin fails++; $display("FAIL coll_sticky: got %0b expected 1", err_sticky); end
        tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL coll_pulse: got %0b expected 1", err_pulse); end
        tests++; if (s_err_cnt !== 2'd1) begin fails++; $display("FAIL coll_small_err_cnt: got %0d expected 1", s_err_cnt); end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        tests++; if (err_exp !== 4'd8) begin fails++; $display("FAIL coll_err_exp: got %0d expected 8", err_exp); end
        tests++; if (err_act !== 4'd3) begin fails++; $display("FAIL coll_err_act: got %0d expected 3", err_act); end
`endif
    endtask

    task automatic test_clear_alone;
        // prev is 3 in SYNC; relock then clear while locked
        drive(1'b1, 4'd4, 1'b0);
        drive(1'b1, 4'd5, 1'b0);
        drive(1'b1, 4'd6, 1'b1);
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL clr_err_cnt: got %0d expected 0", err_cnt); end
        tests++; if (err_sticky !== 1'b0) begin fails++; $display("FAIL clr_sticky: got %0b expected 0", err_sticky); end
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL clr_locked: got %0b expected 1", locked); end
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        tests++; if (err_exp !== 4'd0 || err_act !== 4'd0) begin fails++; $display("FAIL clr_capture: got %0d/%0d expected 0/0", err_exp, err_act); end
`endif
    endtask

`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
    task automatic test_capture;
        // prev is 6 and locked, capture empty
        drive(1'b1, 4'd7, 1'b0);
        drive(1'b1, 4'd2, 1'b0);
        tests++; if (err_exp !== 4'd8) begin fails++; $display("FAIL cap_err_exp: got %0d expected 8", err_exp); end
        tests++; if (err_act !== 4'd2) begin fails++; $display("FAIL cap_err_act: got %0d expected 2", err_act); end
        drive(1'b1, 4'd3, 1'b0);
        drive(1'b1, 4'd4, 1'b0);
        drive(1'b1, 4'd12, 1'b0);
        tests++; if (err_pulse !== 1'b1) begin fails++; $display("FAIL cap_second_pulse: got %0b expected 1", err_pulse); end
        tests++; if (err_exp !== 4'd8 || err_act !== 4'd2) begin fails++; $display("FAIL cap_frozen: got %0d/%0d expected 8/2", err_exp, err_act); end
        drive(1'b0, 4'd0, 1'b1);
        tests++; if (err_exp !== 4'd0 || err_act !== 4'd0) begin fails++; $display("FAIL cap_clear: got %0d/%0d expected 0/0", err_exp, err_act); end
    endtask
`endif

    task automatic test_saturation;
        logic [3:0] p;
        @(negedge clk);
        en = 1'b0; clr_err = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        drive(1'b1, 4'd1, 1'b0);
        drive(1'b1, 4'd2, 1'b0);
        drive(1'b1, 4'd3, 1'b0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL sat_locked: got %0b expected 1", locked); end
        p = 4'd3;
        for (int i = 0; i < 5; i++) begin
            p = p + 4'd5;
            drive(1'b1, p, 1'b0);
            tests++; if (s_err_pulse !== 1'b1) begin fails++; $display("FAIL sat_pulse_%0d: got %0b expected 1", i, s_err_pulse); end
            if (i < 4) begin
                p = p + 4'd1; drive(1'b1, p, 1'b0);
                p = p + 4'd1; drive(1'b1, p, 1'b0);
            end
        end
        tests++; if (s_err_cnt !== 2'd3) begin fails++; $display("FAIL sat_small_err_cnt: got %0d expected 3", s_err_cnt); end
        tests++; if (s_err_sticky !== 1'b1) begin fails++; $display("FAIL sat_small_sticky: got %0b expected 1", s_err_sticky); end
        tests++; if (err_cnt !== 8'd5) begin fails++; $display("FAIL sat_err_cnt: got %0d expected 5", err_cnt); end
    endtask

    task automatic test_async_reset;
        // 1 ns after a rising edge, err_pulse high from the last error
        #2;
        reset = 1'b0;
        #1;
        tests++; if (err_pulse !== 1'b0 || s_err_pulse !== 1'b0) begin fails++; $display("FAIL areset_pulse: got %0b/%0b expected 0/0", err_pulse, s_err_pulse); end
        tests++; if (err_sticky !== 1'b0 || s_err_sticky !== 1'b0) begin fails++; $display("FAIL areset_sticky: got %0b/%0b expected 0/0", err_sticky, s_err_sticky); end
        tests++; if (err_cnt !== 8'd0 || s_err_cnt !== 2'd0) begin fails++; $display("FAIL areset_err_cnt: got %0d/%0d expected 0/0", err_cnt, s_err_cnt); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL areset_locked: got %0b expected 0", locked); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 4'd9, 1'b0);
        tests++; if (err_pulse !== 1'b0) begin fails++; $display("FAIL post_reset_pulse: got %0b expected 0", err_pulse); end
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL post_reset_locked: got %0b expected 0", locked); end
        drive(1'b1, 4'd10, 1'b0);
        drive(1'b1, 4'd11, 1'b0);
        tests++; if (locked !== 1'b1) begin fails++; $display("FAIL post_reset_relock: got %0b expected 1", locked); end
        tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL post_reset_err_cnt: got %0d expected 0", err_cnt); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_lock_wrap();
        test_glitch();
        test_hold_gating();
        test_clear_collision();
        test_clear_alone();
`ifdef COUNT_SEQ_CHECKER_CAPTURE_EN
        test_capture();
`endif
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
